// File: rtl/acquisition_controller_if.sv
// Bundles the acquisition controller's command, configuration, RAM-write and status signals.
// With ACQ_FORCE_TRIGGER_EN defined the bundle also carries a force_trigger request.
interface acquisition_controller_if #(
  parameter int ADDR_WIDTH    = 8,
  parameter int TIMEOUT_WIDTH = 16
);
  logic                     start;
  logic                     abort;
  logic                     sample_valid;
  logic                     triggered;
`ifdef ACQ_FORCE_TRIGGER_EN
  logic                     force_trigger;
`endif
  logic [ADDR_WIDTH-1:0]    pretrigger;
  logic [ADDR_WIDTH-1:0]    posttrigger;
  logic                     auto_mode;
  logic [TIMEOUT_WIDTH-1:0] auto_timeout;
  logic                     wr_en;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [ADDR_WIDTH-1:0]    trigger_addr;
  logic                     busy;
  logic                     done;
  logic                     auto_fired;

  // master: whoever commands captures and consumes status; slave: the controller
  modport master (
`ifdef ACQ_FORCE_TRIGGER_EN
    output force_trigger,
`endif
    output start, abort, sample_valid, triggered,
    output pretrigger, posttrigger, auto_mode, auto_timeout,
    input  wr_en, wr_addr, trigger_addr, busy, done, auto_fired
  );

  modport slave (
`ifdef ACQ_FORCE_TRIGGER_EN
    input  force_trigger,
`endif
    input  start, abort, sample_valid, triggered,
    input  pretrigger, posttrigger, auto_mode, auto_timeout,
    output wr_en, wr_addr, trigger_addr, busy, done, auto_fired
  );
endinterface

// File: rtl/acquisition_controller.sv
// Sequences one oscilloscope capture (pre-trigger fill, arm, post-trigger) into a circular RAM.
// Optional ACQ_FORCE_TRIGGER_EN: force_trigger acts as a trigger event while armed.
module acquisition_controller #(
  parameter int ADDR_WIDTH    = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  acquisition_controller_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]      CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_reg, state_next;
  logic [ADDR_WIDTH-1:0]    addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0]    trig_addr_reg, trig_addr_next;
  logic [ADDR_WIDTH-1:0]    pre_reg, pre_next;
  logic [ADDR_WIDTH-1:0]    post_reg, post_next;
  logic [ADDR_WIDTH:0]      cnt_reg, cnt_next, cnt_inc;
  logic [TIMEOUT_WIDTH-1:0] tmo_reg, tmo_next;
  logic [TIMEOUT_WIDTH-1:0] tmo_lim_reg, tmo_lim_next;
  logic                     auto_mode_reg, auto_mode_next;
  logic                     auto_fired_reg, auto_fired_next;
  logic                     capturing;
  logic                     write;
  logic                     ext_trig;
  logic                     timeout_hit;

  assign capturing   = (state_reg == FILL) || (state_reg == ARMED) || (state_reg == POST);
  assign write       = bus.sample_valid && capturing;
  assign cnt_inc     = cnt_reg + CNT_ONE;
  assign timeout_hit = auto_mode_reg && (tmo_reg == tmo_lim_reg);
`ifdef ACQ_FORCE_TRIGGER_EN
  assign ext_trig    = bus.triggered || bus.force_trigger;
`else
  assign ext_trig    = bus.triggered;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      trig_addr_reg  <= '0;
      pre_reg        <= '0;
      post_reg       <= '0;
      cnt_reg        <= '0;
      tmo_reg        <= '0;
      tmo_lim_reg    <= '0;
      auto_mode_reg  <= 1'b0;
      auto_fired_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      trig_addr_reg  <= trig_addr_next;
      pre_reg        <= pre_next;
      post_reg       <= post_next;
      cnt_reg        <= cnt_next;
      tmo_reg        <= tmo_next;
      tmo_lim_reg    <= tmo_lim_next;
      auto_mode_reg  <= auto_mode_next;
      auto_fired_reg <= auto_fired_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    addr_next       = write ? addr_reg + ADDR_ONE : addr_reg;
    cnt_next        = write ? cnt_inc : cnt_reg;
    trig_addr_next  = trig_addr_reg;
    pre_next        = pre_reg;
    post_next       = post_reg;
    tmo_next        = tmo_reg;
    tmo_lim_next    = tmo_lim_reg;
    auto_mode_next  = auto_mode_reg;
    auto_fired_next = auto_fired_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (bus.start && !bus.abort) begin
          state_next      = FILL;
          addr_next       = '0;
          cnt_next        = '0;
          tmo_next        = '0;
          auto_fired_next = 1'b0;
          pre_next        = bus.pretrigger;
          post_next       = bus.posttrigger;
          tmo_lim_next    = bus.auto_timeout;
          auto_mode_next  = bus.auto_mode;
        end
      end
      FILL: begin
        if ((pre_reg == '0) || (write && (cnt_inc == {1'b0, pre_reg}))) begin
          state_next = ARMED;
          cnt_next   = '0;
        end
      end
      ARMED: begin
        tmo_next = tmo_reg + TMO_ONE;
        if (ext_trig || timeout_hit) begin
          state_next      = POST;
          trig_addr_next  = addr_reg;
          // the trigger sample itself is the first post-trigger write
          cnt_next        = write ? CNT_ONE : '0;
          auto_fired_next = !ext_trig;
        end
      end
      POST: begin
        if ((cnt_reg >= {1'b0, post_reg}) || (write && (cnt_inc == {1'b0, post_reg}))) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (bus.abort) begin
      state_next = IDLE;
    end
  end

  assign bus.wr_en        = write;
  assign bus.wr_addr      = addr_reg;
  assign bus.trigger_addr = trig_addr_reg;
  assign bus.busy         = capturing;
  assign bus.done         = (state_reg == DONE);
  assign bus.auto_fired   = auto_fired_reg;
endmodule

// File: tb/tb_acquisition_controller.sv
// Scoreboard bench for acquisition_controller: stimulus queues expected RAM writes and
// capture results; a negedge monitor pops and compares whenever the DUT writes or completes.
module tb_acquisition_controller;
  localparam int AW = 8;
  localparam int TW = 16;

  typedef struct packed {
    logic          af;
    logic [AW-1:0] taddr;
  } done_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [AW-1:0] exp_wr_q[$];
  done_t         exp_done_q[$];
  logic [AW-1:0] exp_addr;
  done_t         exp_done;
  logic          done_d = 1'b0;

  always #5 clk = ~clk;

  acquisition_controller_if #(.ADDR_WIDTH(AW), .TIMEOUT_WIDTH(TW)) bus ();

  acquisition_controller #(.ADDR_WIDTH(AW), .TIMEOUT_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // monitor: every write and every capture completion is matched against the queues
  always @(negedge clk) begin
    if (reset) begin
      if (bus.wr_en) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected actual addr=%0d required=no write", bus.wr_addr);
        end else begin
          exp_addr = exp_wr_q.pop_front();
          if (bus.wr_addr !== exp_addr) begin
            errors++;
            $display("FAIL wr_addr actual=%0d required=%0d", bus.wr_addr, exp_addr);
          end else begin
            $display("write addr=%0d ok", bus.wr_addr);
          end
        end
      end
      if (bus.done && !done_d) begin
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected actual trigger_addr=%0d required=no completion",
                   bus.trigger_addr);
        end else begin
          exp_done = exp_done_q.pop_front();
          if (bus.trigger_addr !== exp_done.taddr || bus.auto_fired !== exp_done.af) begin
            errors++;
            $display("FAIL done_record actual trigger_addr=%0d auto_fired=%0d required trigger_addr=%0d auto_fired=%0d",
                     bus.trigger_addr, bus.auto_fired, exp_done.taddr, exp_done.af);
          end else begin
            $display("done trigger_addr=%0d auto_fired=%0d ok", bus.trigger_addr, bus.auto_fired);
          end
        end
      end
    end
    done_d <= bus.done;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_range(input int first, input int n);
    for (int i = 0; i < n; i++) exp_wr_q.push_back(AW'(first + i));
  endtask

  task automatic push_done(input int taddr, input logic af);
    done_t d;
    d.taddr = AW'(taddr);
    d.af    = af;
    exp_done_q.push_back(d);
  endtask

  task automatic config_cap(input int pre, input int post, input logic am, input int tmo);
    bus.pretrigger   = AW'(pre);
    bus.posttrigger  = AW'(post);
    bus.auto_mode    = am;
    bus.auto_timeout = TW'(tmo);
  endtask

  // start pulse issued in cycle 0; returns in cycle 1 (first FILL cycle)
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
    chk({tag, "_trigger_addr"}, 32'(bus.trigger_addr), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_auto_fired"}, 32'(bus.auto_fired), 0);
  endtask

  initial begin
    reset            = 1'b0;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.triggered    = 1'b0;
`ifdef ACQ_FORCE_TRIGGER_EN
    bus.force_trigger = 1'b0;
`endif
    config_cap(0, 0, 1'b0, 0);
    ticks(2);
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // basic capture: 4 pre, trigger at ARMED clock 10, 4 post
    config_cap(4, 4, 1'b0, 0);
    bus.sample_valid = 1'b1;
    push_range(0, 18);
    push_done(14, 1'b0);
    pulse_start();                          // cycle 1
    chk("basic_busy_fill", 32'(bus.busy), 1);
    ticks(14);                              // cycle 15
    bus.triggered = 1'b1;
    tick();
    bus.triggered = 1'b0;                   // cycle 16
    ticks(2);                               // cycle 18, last POST write
    chk("basic_done_early", 32'(bus.done), 0);
    chk("basic_busy_post", 32'(bus.busy), 1);
    tick();                                 // cycle 19
    chk("basic_done", 32'(bus.done), 1);
    chk("basic_busy_done", 32'(bus.busy), 0);
    chk("basic_wr_en_done", 32'(bus.wr_en), 0);
    chk("basic_trigger_addr", 32'(bus.trigger_addr), 14);
    ticks(2);
    chk("basic_done_held", 32'(bus.done), 1);
    chk("basic_wr_en_held", 32'(bus.wr_en), 0);

    // abort in POST
    config_cap(2, 8, 1'b0, 0);
    push_range(0, 5);
    pulse_start();                          // cycle 1
    chk("abort_done_cleared", 32'(bus.done), 0);
    ticks(2);                               // cycle 3, ARMED
    bus.triggered = 1'b1;
    tick();
    bus.triggered = 1'b0;                   // cycle 4, POST
    tick();                                 // cycle 5
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;                       // cycle 6
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_wr_en", 32'(bus.wr_en), 0);
    chk("abort_trigger_addr_kept", 32'(bus.trigger_addr), 2);

    // start and abort together: no capture
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_busy", 32'(bus.busy), 0);
    chk("start_abort_wr_en", 32'(bus.wr_en), 0);
    tick();
    chk("start_abort_busy_later", 32'(bus.busy), 0);

    // triggered pulses during FILL are ignored
    config_cap(8, 2, 1'b0, 0);
    push_range(0, 13);
    push_done(11, 1'b0);
    pulse_start();                          // cycle 1
    tick();                                 // cycle 2
    bus.triggered = 1'b1;
    tick();
    bus.triggered = 1'b0;                   // cycle 3
    ticks(2);                               // cycle 5
    bus.triggered = 1'b1;
    tick();
    bus.triggered = 1'b0;                   // cycle 6
    ticks(6);                               // cycle 12, ARMED clock 3
    bus.triggered = 1'b1;
    tick();
    bus.triggered = 1'b0;                   // cycle 13
    tick();                                 // cycle 14
    chk("filltrig_done", 32'(bus.done), 1);
    chk("filltrig_trigger_addr", 32'(bus.trigger_addr), 11);

    // auto mode: timeout fires at ARMED clock 20; config changes mid-capture ignored
    config_cap(4, 4, 1'b1, 20);
    push_range(0, 28);
    push_done(24, 1'b1);
    pulse_start();                          // cycle 1
    config_cap(100, 1, 1'b0, 3);
    ticks(28);                              // cycle 29
    chk("auto_done", 32'(bus.done), 1);
    chk("auto_fired", 32'(bus.auto_fired), 1);
    chk("auto_trigger_addr", 32'(bus.trigger_addr), 24);

    // auto mode beaten by a real trigger at ARMED clock 5
    config_cap(4, 4, 1'b1, 20);
    push_range(0, 13);
    push_done(9, 1'b0);
    pulse_start();                          // cycle 1
    chk("auto2_fired_cleared", 32'(bus.auto_fired), 0);
    ticks(9);                               // cycle 10
    bus.triggered = 1'b1;
    tick();
    bus.triggered = 1'b0;                   // cycle 11
    ticks(3);                               // cycle 14
    chk("auto2_done", 32'(bus.done), 1);
    chk("auto2_fired", 32'(bus.auto_fired), 0);

    // zero windows with gapped samples
    config_cap(0, 0, 1'b0, 0);
    push_range(0, 2);
    push_done(1, 1'b0);
    bus.sample_valid = 1'b1;
    pulse_start();                          // cycle 1, FILL
    bus.sample_valid = 1'b0;
    chk("zero_busy_fill", 32'(bus.busy), 1);
    tick();                                 // cycle 2, ARMED
    bus.sample_valid = 1'b1;
    tick();                                 // cycle 3
    bus.sample_valid = 1'b0;
    bus.triggered = 1'b1;
    tick();                                 // cycle 4, POST
    bus.triggered = 1'b0;
    bus.sample_valid = 1'b1;
    chk("zero_done_post", 32'(bus.done), 0);
    chk("zero_busy_post", 32'(bus.busy), 1);
    tick();                                 // cycle 5, DONE
    bus.sample_valid = 1'b0;
    chk("zero_done", 32'(bus.done), 1);
    chk("zero_busy_done", 32'(bus.busy), 0);
    chk("zero_trigger_addr", 32'(bus.trigger_addr), 1);
    tick();
    bus.sample_valid = 1'b1;
    chk("zero_wr_en_done", 32'(bus.wr_en), 0);
    tick();

    // wrap-around: trigger at ARMED write 260 -> (3 + 260) mod 256 = 7
    config_cap(3, 5, 1'b0, 0);
    push_range(0, 268);
    push_done(7, 1'b0);
    pulse_start();                          // cycle 1
    ticks(263);                             // cycle 264
    bus.triggered = 1'b1;
    tick();
    bus.triggered = 1'b0;                   // cycle 265
    ticks(4);                               // cycle 269
    chk("wrap_done", 32'(bus.done), 1);
    chk("wrap_trigger_addr", 32'(bus.trigger_addr), 7);

    // asynchronous reset mid-ARMED
    config_cap(2, 4, 1'b0, 0);
    push_range(0, 3);
    pulse_start();                          // cycle 1
    ticks(3);                               // cycle 4, ARMED
    chk("rst_busy_before", 32'(bus.busy), 1);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    reset = 1'b1;
    ticks(3);

    chk("wr_queue_drained", 32'(exp_wr_q.size()), 0);
    chk("done_queue_drained", 32'(exp_done_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
